// File: rtl/fft_window_reader_pkg.sv
// Shared types and constants for the FFT window read-side sequencer.
// Holds the buffer geometry, the sequencer states and the round-robin helper.
package fft_window_reader_pkg;

    localparam int N_POINTS = 1024;
    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 16;
    localparam int N_BUF    = 3;

    typedef logic [1:0]        buf_idx_t;
    typedef logic [ADDR_W:0]   cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] tdata;
        logic              tlast;
        buf_idx_t          tuser;
    } beat_t;

    typedef struct packed {
        logic     found;
        buf_idx_t idx;
    } rr_grant_t;

    // Scans last+3 down to last+1 so the final hit is the first candidate
    // in round-robin order starting at (last + 1) mod N_BUF.
    function automatic rr_grant_t rr_pick(input logic [N_BUF-1:0] req,
                                          input buf_idx_t         last);
        rr_grant_t g;
        buf_idx_t  cand;
        g = '0;
        for (int k = N_BUF; k >= 1; k--) begin
            cand = buf_idx_t'((int'(last) + k) % N_BUF);
            if (req[cand]) begin
                g.found = 1'b1;
                g.idx   = cand;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/fft_window_reader_if.sv
// Buffer read port plus the outgoing sample stream of the window reader.
// master = the reader; slave = the window buffers and the FFT core.
interface fft_window_reader_if;
    import fft_window_reader_pkg::*;

    logic              buf_rd_en;
    buf_idx_t          buf_rd_sel;
    logic [ADDR_W-1:0] buf_rd_addr;
    logic [DATA_W-1:0] buf_rd_data_0;
    logic [DATA_W-1:0] buf_rd_data_1;
    logic [DATA_W-1:0] buf_rd_data_2;

    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;
    buf_idx_t          m_tuser;

    modport master (
        output buf_rd_en, buf_rd_sel, buf_rd_addr,
        input  buf_rd_data_0, buf_rd_data_1, buf_rd_data_2,
        output m_tdata, m_tvalid, m_tlast, m_tuser,
        input  m_tready
    );

    modport slave (
        input  buf_rd_en, buf_rd_sel, buf_rd_addr,
        output buf_rd_data_0, buf_rd_data_1, buf_rd_data_2,
        input  m_tdata, m_tvalid, m_tlast, m_tuser,
        output m_tready
    );

endinterface

// File: rtl/fft_stream_skid_fifo.sv
// Two-entry FIFO of stream beats {tdata, tlast, tuser} with push/pop/count.
// Absorbs read data that is already in flight when the consumer stalls.
module fft_stream_skid_fifo
    import fft_window_reader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  beat_t      i_push_beat,
    input  logic       i_pop,
    output beat_t      o_head,
    output logic       o_empty,
    output logic [1:0] o_count
);

    beat_t      r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: storage is reset too, so the head reads 0 rather than X out of reset.
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_beat;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/fft_window_reader.sv
// Reads completed 1024-sample windows out of three overlapping buffers in
// address order and streams them to the FFT core with tlast/tuser markers.
module fft_window_reader
    import fft_window_reader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [N_BUF-1:0]    i_win_ready,
    fft_window_reader_if.master bus,
    output logic                o_busy,
    output logic                o_overrun,
    output buf_idx_t            o_overrun_idx
);

    state_t            r_state;
    logic [N_BUF-1:0]  r_pending;
    buf_idx_t          r_last_served;
    buf_idx_t          r_cur_sel;
    cnt_t              r_rd_cnt;
    logic              r_rd_valid;
    buf_idx_t          r_rd_sel;
    cnt_t              r_rd_idx;
    logic              r_overrun;
    buf_idx_t          r_overrun_idx;

    state_t            w_next_state;
    rr_grant_t         w_grant;
    logic              w_arb;
    logic [N_BUF-1:0]  w_clear;
    logic [N_BUF-1:0]  w_ovr_hit;
    buf_idx_t          w_ovr_idx;
    logic              w_issue;
    logic              w_pop;
    logic [2:0]        w_occupancy;
    logic [DATA_W-1:0] w_rd_data;
    beat_t             w_push_beat;
    beat_t             w_head;
    logic              w_fifo_empty;
    logic [1:0]        w_fifo_count;

    // Outstanding samples (queued + in flight) are capped at the FIFO depth,
    // so a returning read always has a free slot even under backpressure.
    assign w_pop       = !w_fifo_empty && bus.m_tready;
    assign w_occupancy = {1'b0, w_fifo_count} + {2'b00, r_rd_valid};
    assign w_issue     = (r_state == READ) && (w_occupancy < (3'd2 + {2'b00, w_pop}));

    assign w_grant = rr_pick(r_pending, r_last_served);
    assign w_arb   = (r_state == IDLE) && w_grant.found;
    assign w_clear = w_arb ? (3'b001 << w_grant.idx) : '0;

    always_comb begin
        // NOTE: every always_comb output gets a default first; a missed branch would infer a latch.
        w_ovr_hit = '0;
        w_ovr_idx = '0;
        for (int i = 0; i < N_BUF; i++) begin
            if (i_win_ready[i] &&
                (r_pending[i] || ((r_state != IDLE) && (r_cur_sel == buf_idx_t'(i))))) begin
                w_ovr_hit[i] = 1'b1;
                w_ovr_idx    = buf_idx_t'(i);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:  if (w_grant.found) w_next_state = READ;
            READ:  if (w_issue && (r_rd_cnt == cnt_t'(N_POINTS - 1))) w_next_state = DRAIN;
            DRAIN: if (w_pop && w_head.tlast) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending     <= '0;
            r_last_served <= buf_idx_t'(2);
            r_cur_sel     <= '0;
            r_rd_cnt      <= '0;
            r_rd_valid    <= 1'b0;
            r_rd_sel      <= '0;
            r_rd_idx      <= '0;
            r_overrun     <= 1'b0;
            r_overrun_idx <= '0;
        end else begin
            // A duplicate request is dropped; only the overrun flag records it.
            r_pending <= (r_pending & ~w_clear) | (i_win_ready & ~w_ovr_hit);

            if (w_arb) begin
                r_cur_sel     <= w_grant.idx;
                r_last_served <= w_grant.idx;
            end

            if (r_state == IDLE) begin
                r_rd_cnt <= '0;
            end else if (w_issue) begin
                r_rd_cnt <= r_rd_cnt + cnt_t'(1);
            end

            r_rd_valid <= w_issue;
            r_rd_sel   <= r_cur_sel;
            r_rd_idx   <= r_rd_cnt;

            if (|w_ovr_hit) begin
                r_overrun     <= 1'b1;
                r_overrun_idx <= w_ovr_idx;
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        unique case (r_rd_sel)
            2'd0:    w_rd_data = bus.buf_rd_data_0;
            2'd1:    w_rd_data = bus.buf_rd_data_1;
            2'd2:    w_rd_data = bus.buf_rd_data_2;
            default: w_rd_data = '0;
        endcase
    end

    // tlast travels with the issue index rather than being counted at the output.
    assign w_push_beat.tdata = w_rd_data;
    assign w_push_beat.tlast = (r_rd_idx == cnt_t'(N_POINTS - 1));
    assign w_push_beat.tuser = r_rd_sel;

    fft_stream_skid_fifo u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (r_rd_valid),
        .i_push_beat (w_push_beat),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign bus.buf_rd_en   = w_issue;
    assign bus.buf_rd_sel  = r_cur_sel;
    assign bus.buf_rd_addr = r_rd_cnt[ADDR_W-1:0];

    assign bus.m_tvalid = !w_fifo_empty;
    assign bus.m_tdata  = w_head.tdata;
    assign bus.m_tlast  = w_head.tlast;
    assign bus.m_tuser  = w_head.tuser;

    assign o_busy        = (r_state != IDLE);
    assign o_overrun     = r_overrun;
    assign o_overrun_idx = r_overrun_idx;

endmodule
